// File: rtl/rr_stage.sv
// Register-read stage: operand resolution with EX/MEM forwarding, load-use bubbles, LM/SM micro-op expansion.
// Optional macro RR_HAZ_CNT_EN adds a saturating load-use bubble counter on haz_cnt.
module rr_stage #(
    parameter int W    = 16,
    parameter int NREG = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [W-1:0]             in_instr,
    input  logic [W-1:0]             in_pc,
    input  logic                     flush,
    input  logic                     ex_hold,
    output logic [$clog2(NREG)-1:0]  rf_addr_a,
    output logic [$clog2(NREG)-1:0]  rf_addr_b,
    input  logic [W-1:0]             rf_data_a,
    input  logic [W-1:0]             rf_data_b,
    input  logic                     ex_wr_en,
    input  logic [$clog2(NREG)-1:0]  ex_wr_addr,
    input  logic [W-1:0]             ex_wr_data,
    input  logic                     ex_is_load,
    input  logic                     mem_wr_en,
    input  logic [$clog2(NREG)-1:0]  mem_wr_addr,
    input  logic [W-1:0]             mem_wr_data,
    output logic                     stall_up,
    output logic                     out_valid,
    output logic [W-1:0]             out_instr,
    output logic [W-1:0]             out_pc,
    output logic [W-1:0]             out_opa,
    output logic [W-1:0]             out_opb,
    output logic [$clog2(NREG)-1:0]  out_dest
`ifdef RR_HAZ_CNT_EN
    ,
    output logic [15:0]              haz_cnt
`endif
);

    localparam int RW = $clog2(NREG);
    localparam logic [RW-1:0] PC_REG = RW'(NREG - 1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_SM  = 4'b0111;
    localparam logic [3:0] OP_JAL = 4'b1000;
    localparam logic [3:0] OP_JLR = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1100;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_MULTI = 1'b1;

    logic [0:0]      state;
    logic [NREG-1:0] mask_p1;
    logic [W-1:0]    base_p1;
    logic [RW:0]     k_p1;

    function automatic logic [W-1:0] resolve(
        input logic [RW-1:0] s,
        input logic [W-1:0]  rf_val,
        input logic [W-1:0]  pc,
        input logic          exen,
        input logic [RW-1:0] exaddr,
        input logic [W-1:0]  exdata,
        input logic          exld,
        input logic          memen,
        input logic [RW-1:0] memaddr,
        input logic [W-1:0]  memdata
    );
        if (s == PC_REG)                          resolve = pc;
        else if (exen && exaddr == s && !exld)    resolve = exdata;
        else if (memen && memaddr == s)           resolve = memdata;
        else                                      resolve = rf_val;
    endfunction

    function automatic logic [RW-1:0] lowest_set(input logic [NREG-1:0] m);
        lowest_set = '0;
        for (int i = NREG - 1; i >= 0; i--)
            if (m[i]) lowest_set = RW'(i);
    endfunction

    function automatic logic [RW-1:0] dest_of(
        input logic [3:0] op,
        input logic [RW-1:0] a,
        input logic [RW-1:0] b,
        input logic [RW-1:0] c
    );
        case (op)
            OP_ADD, OP_NDU:                 dest_of = c;
            OP_ADI:                         dest_of = b;
            OP_LHI, OP_LW, OP_JAL, OP_JLR:  dest_of = a;
            default:                        dest_of = '0;
        endcase
    endfunction

    logic [3:0]      op;
    logic [RW-1:0]   ra, rb, rc;
    logic [NREG-1:0] imm, cur_mask, rest_mask;
    logic [RW-1:0]   bit_i;
    logic            multi, is_lmsm, is_sm, imm_nz, lmsm_go, sm_uop, more;
    logic            use_a, use_b, cur_valid, hazard;
    logic [W-1:0]    res_a, res_b;

    assign op        = in_instr[15:12];
    assign ra        = in_instr[11:9];
    assign rb        = in_instr[8:6];
    assign rc        = in_instr[5:3];
    assign imm       = in_instr[NREG-1:0];
    assign multi     = (state == S_MULTI);
    assign is_lmsm   = (op == OP_LM) || (op == OP_SM);
    assign is_sm     = (op == OP_SM);
    assign imm_nz    = (imm != '0);
    assign cur_mask  = multi ? mask_p1 : imm;
    assign bit_i     = lowest_set(cur_mask);
    // Clearing the lowest set bit leaves the registers still to be transferred.
    assign rest_mask = cur_mask & (cur_mask - NREG'(1));
    assign lmsm_go   = multi || (in_valid && is_lmsm && imm_nz);
    assign sm_uop    = is_sm && lmsm_go;
    assign more      = lmsm_go && (rest_mask != '0);
    assign cur_valid = in_valid || multi;

    assign rf_addr_a = ra;
    assign rf_addr_b = sm_uop ? bit_i : rb;

    assign res_a = resolve(ra, rf_data_a, in_pc, ex_wr_en, ex_wr_addr, ex_wr_data,
                           ex_is_load, mem_wr_en, mem_wr_addr, mem_wr_data);
    assign res_b = resolve(rf_addr_b, rf_data_b, in_pc, ex_wr_en, ex_wr_addr, ex_wr_data,
                           ex_is_load, mem_wr_en, mem_wr_addr, mem_wr_data);

    // Base register is read only on the first micro-op of a multiple transfer.
    always_comb begin
        use_a = 1'b0;
        use_b = 1'b0;
        if (multi) begin
            use_b = is_sm;
        end else begin
            case (op)
                OP_ADD, OP_NDU, OP_SW, OP_BEQ: begin use_a = 1'b1; use_b = 1'b1; end
                OP_ADI:                        use_a = 1'b1;
                OP_LW, OP_JLR:                 use_b = 1'b1;
                OP_LM:                         use_a = imm_nz;
                OP_SM:                         begin use_a = imm_nz; use_b = imm_nz; end
                default:                       ;
            endcase
        end
    end

    assign hazard = cur_valid && ex_wr_en && ex_is_load &&
                    ((use_a && ra != PC_REG && ex_wr_addr == ra) ||
                     (use_b && rf_addr_b != PC_REG && ex_wr_addr == rf_addr_b));

    assign stall_up = !reset && !flush && (ex_hold || hazard || more);

    // RR/EX pipeline register boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            out_opa   <= '0;
            out_opb   <= '0;
            out_dest  <= '0;
            state     <= S_IDLE;
            mask_p1   <= '0;
            base_p1   <= '0;
            k_p1      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
            mask_p1   <= '0;
        end else if (ex_hold) begin
            out_valid <= out_valid;
        end else if (hazard) begin
            out_valid <= 1'b0;
        end else if (lmsm_go) begin
            out_valid <= 1'b1;
            out_dest  <= bit_i;
            out_opb   <= res_b;
            mask_p1   <= rest_mask;
            state     <= (rest_mask != '0) ? S_MULTI : S_IDLE;
            if (multi) begin
                out_opa <= base_p1 + W'(k_p1);
                k_p1    <= k_p1 + (RW+1)'(1);
            end else begin
                base_p1   <= res_a;
                out_opa   <= res_a;
                out_instr <= in_instr;
                out_pc    <= in_pc;
                k_p1      <= (RW+1)'(1);
            end
        end else if (in_valid && is_lmsm) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out_instr <= in_instr;
            out_pc    <= in_pc;
            out_opa   <= res_a;
            out_opb   <= res_b;
            out_dest  <= dest_of(op, ra, rb, rc);
        end
    end

`ifdef RR_HAZ_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            haz_cnt <= '0;
        else if (!flush && !ex_hold && hazard && haz_cnt != 16'hFFFF)
            haz_cnt <= haz_cnt + 16'd1;
    end
`endif

endmodule
